// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multi-cycle multiply/divide controller for the E stage.
// A start pulse latches the operation result into a pending {hi,lo} register.
// The unit then holds obusy for a fixed number of cycles and commits to HI/LO
// on the edge where obusy falls. MTHI/MTLO write HI/LO directly in one cycle.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous, active-high; clears all state
//   istart  in   1   E-stage MDU op this cycle
//   iop     in   3   1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; 0,7=no-op
//   iA1     in   32  rs operand
//   iA2     in   32  rt operand
//   obusy   out  1   multi-cycle op in flight
//   ostall  out  1   obusy | (istart & iop in 1..4), combinational
//   ohi     out  32  HI register
//   olo     out  32  LO register
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        istart,
  input  logic [2:0]  iop,
  input  logic [31:0] iA1,
  input  logic [31:0] iA2,
  output logic        obusy,
  output logic        ostall,
  output logic [31:0] ohi,
  output logic [31:0] olo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [63:0]     r_pend;
  logic            r_dz;

  logic            w_is_md;
  logic            w_is_mult;
  logic            w_accept;
  logic [63:0]     w_prod_s;
  logic [63:0]     w_prod_u;
  logic [31:0]     w_mag_a;
  logic [31:0]     w_mag_b;
  logic [31:0]     w_dvd;
  logic [31:0]     w_dvs;
  logic [31:0]     w_q;
  logic [31:0]     w_r;
  logic [31:0]     w_q_fix;
  logic [31:0]     w_r_fix;
  logic [63:0]     w_result;

  assign w_is_md   = (iop >= 3'd1) && (iop <= 3'd4);
  assign w_is_mult = (iop == 3'd1) || (iop == 3'd2);
  assign w_accept  = (r_state == S_IDLE) && istart && w_is_md;

  // Arithmetic for the op presented on the start cycle.
  always_comb begin
    // Low 64 bits of a product of sign-extended operands equal the signed
    // 32x32 product, so no signed types are needed.
    w_prod_s = {{32{iA1[31]}}, iA1} * {{32{iA2[31]}}, iA2};
    w_prod_u = {32'd0, iA1} * {32'd0, iA2};

    // Signed divide is done on magnitudes; |0x80000000| stays 0x80000000 as an
    // unsigned value, which makes the 0x80000000 / -1 case wrap naturally.
    w_mag_a = iA1[31] ? (32'd0 - iA1) : iA1;
    w_mag_b = iA2[31] ? (32'd0 - iA2) : iA2;
    w_dvd   = (iop == 3'd3) ? w_mag_a : iA1;
    w_dvs   = (iop == 3'd3) ? w_mag_b : iA2;
    // Divisor 0 is never committed; substitute 1 to keep the divider defined.
    if (w_dvs == 32'd0) w_dvs = 32'd1;
    w_q = w_dvd / w_dvs;
    w_r = w_dvd % w_dvs;

    w_q_fix = w_q;
    w_r_fix = w_r;
    if (iop == 3'd3) begin
      if (iA1[31] ^ iA2[31]) w_q_fix = 32'd0 - w_q;
      if (iA1[31])           w_r_fix = 32'd0 - w_r;
    end

    case (iop)
      3'd1:    w_result = w_prod_s;
      3'd2:    w_result = w_prod_u;
      default: w_result = {w_r_fix, w_q_fix};
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)       w_next = S_BUSY;
      S_BUSY: if (r_cnt == '0)    w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    obusy  = (r_state == S_BUSY);
    ostall = obusy | (istart & w_is_md);
  end

  // Counter, pending result and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_pend <= '0;
      r_dz   <= 1'b0;
      ohi    <= '0;
      olo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pend <= w_result;
            r_dz   <= !w_is_mult && (iA2 == 32'd0);
            r_cnt  <= w_is_mult ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
          end else if (istart && iop == 3'd5) begin
            ohi <= iA1;
          end else if (istart && iop == 3'd6) begin
            olo <= iA1;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (!r_dz) begin
            ohi <= r_pend[63:32];
            olo <= r_pend[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        istart;
  logic [2:0]  iop;
  logic [31:0] iA1, iA2;
  logic        obusy, ostall;
  logic [31:0] ohi, olo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .istart(istart), .iop(iop), .iA1(iA1), .iA2(iA2),
    .obusy(obusy), .ostall(ostall), .ohi(ohi), .olo(olo)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference model: an accepted op is scheduled to complete at an absolute edge index.
  bit [31:0] m_hi, m_lo, m_phi, m_plo;
  bit        m_dz, m_active;
  longint    m_e, m_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_active = 0; m_dz = 0;
  endtask

  task automatic model_edge(input bit st, input bit [2:0] op, input bit [31:0] a, input bit [31:0] b);
    longint sp, q, r;
    longint unsigned up;
    m_e++;
    if (m_active) begin
      if (m_e == m_done) begin
        m_active = 0;
        if (!m_dz) begin m_hi = m_phi; m_lo = m_plo; end
      end
    end else if (st) begin
      case (op)
        3'd1: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          m_phi = sp[63:32]; m_plo = sp[31:0]; m_dz = 0;
        end
        3'd2: begin
          up = longint'({32'd0, a}) * longint'({32'd0, b});
          m_phi = up[63:32]; m_plo = up[31:0]; m_dz = 0;
        end
        3'd3: begin
          m_dz = (b == 0);
          if (!m_dz) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            m_phi = r[31:0]; m_plo = q[31:0];
          end
        end
        3'd4: begin
          m_dz = (b == 0);
          if (!m_dz) begin m_phi = a % b; m_plo = a / b; end
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
      if (op >= 1 && op <= 4) begin
        m_active = 1;
        m_done = m_e + ((op <= 2) ? MC : DC);
      end
    end
  endtask

  // One clock cycle: drive inputs, check stall, take the edge, check registered outputs.
  task automatic cyc(input bit st, input bit [2:0] op, input bit [31:0] a, input bit [31:0] b);
    istart = st; iop = op; iA1 = a; iA2 = b;
    #1;
    chk("ostall", {31'd0, ostall}, {31'd0, m_active | (st && op >= 1 && op <= 4)});
    @(posedge clk); #1;
    model_edge(st, op, a, b);
    chk("obusy", {31'd0, obusy}, {31'd0, m_active});
    chk("ohi", ohi, m_hi);
    chk("olo", olo, m_lo);
  endtask

  // Idle cycles until obusy falls (bounded); returns the number of edges taken.
  task automatic wait_idle(output int n);
    n = 1;
    while (obusy && n < 100) begin
      cyc(0, 3'd0, $urandom, $urandom);
      if (obusy) n++;
    end
    if (obusy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    bit          keep;
  } vec_t;

  vec_t vt[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit [31:0] ph, pl;
    bit [2:0]  rop;
    bit [31:0] ra, rb;

    vt[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vt[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[3] = '{3'd4, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
    vt[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vt[5] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vt[6] = '{3'd3, 32'd1234,     32'd0,        32'd0,        32'd0,        1'b1};
    vt[7] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0};
    vt[8] = '{3'd4, 32'hDEADBEEF, 32'd0,        32'd0,        32'd0,        1'b1};
    vt[9] = '{3'd2, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};

    m_e = 0; m_done = 0;
    model_reset();
    reset = 1'b1; istart = 0; iop = 0; iA1 = 0; iA2 = 0;
    #12;
    chk("rst_obusy", {31'd0, obusy}, 32'd0);
    chk("rst_ohi", ohi, 32'd0);
    chk("rst_olo", olo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table of single operations
    foreach (vt[i]) begin
      ph = ohi; pl = olo;
      cyc(1, vt[i].op, vt[i].a, vt[i].b);
      wait_idle(n);
      chk($sformatf("vec%0d_cycles", i), n, (vt[i].op <= 2) ? MC : DC);
      chk($sformatf("vec%0d_hi", i), ohi, vt[i].keep ? ph : vt[i].hi);
      chk($sformatf("vec%0d_lo", i), olo, vt[i].keep ? pl : vt[i].lo);
    end

    // MTHI then MTLO on consecutive edges
    cyc(1, 3'd5, 32'h12345678, 32'd0);
    chk("mthi", ohi, 32'h12345678);
    cyc(1, 3'd6, 32'hCAFEBABE, 32'd0);
    chk("mtlo", olo, 32'hCAFEBABE);
    chk("mthi_kept", ohi, 32'h12345678);

    // No-op codes
    cyc(1, 3'd0, 32'h1, 32'h1);
    cyc(1, 3'd7, 32'h2, 32'h2);

    // DIV with a MULT start pulsed at busy cycle 3
    cyc(1, 3'd3, 32'd100, 32'd7);
    n = 1;
    while (obusy && n < 100) begin
      if (n == 3) cyc(1, 3'd1, 32'd9, 32'd9);
      else        cyc(0, 3'd0, 32'd0, 32'd0);
      if (obusy) n++;
    end
    chk("ignore_cycles", n, DC);
    chk("ignore_hi", ohi, 32'd2);
    chk("ignore_lo", olo, 32'd14);

    // Reset during busy cycle 2 of a MULT
    cyc(1, 3'd1, 32'd3, 32'd4);
    cyc(0, 3'd0, 32'd0, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_obusy", {31'd0, obusy}, 32'd0);
    chk("midrst_ohi", ohi, 32'd0);
    chk("midrst_olo", olo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) cyc(0, 3'd0, 32'd0, 32'd0);
    chk("no_late_hi", ohi, 32'd0);
    chk("no_late_lo", olo, 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
        3: ra = 32'd0 - $urandom_range(0, 50);
        default: ;
      endcase
      cyc(($urandom_range(0, 2) == 0), rop, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
